// File: rtl/param_register_file.sv
// Parameterised register file with two registered read ports, one write
// port with write-to-read bypass, an optional hard-wired zero register,
// and a clear sweep that zeroes one register per cycle.
//
// Handshake: a write is taken at the rising edge when we=1 and busy=0.
// While busy=1 a write is refused and wr_drop pulses on the following
// cycle. Reads happen at the edge when re=1. They show up on DA/DB one
// cycle later and stay unchanged while re=0.
module param_register_file #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic [DATA_W-1:0] W,
    input  logic              re,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    output logic [DATA_W-1:0] DA,
    output logic [DATA_W-1:0] DB,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop,
    output logic [1:0]        fsm_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                zero_r0_en;
    logic                wr_accept;
    logic                wr_store;
    logic [DATA_W-1:0]   rd_a;
    logic [DATA_W-1:0]   rd_b;

    assign zero_r0_en = (ZERO_R0 != 0);

    // A write is accepted whenever no sweep is running. A write to register 0
    // still counts as accepted when it is hard-wired to zero, but nothing is
    // stored and no drop is reported.
    assign wr_accept = we && !busy;
    assign wr_store  = wr_accept && !(zero_r0_en && (W_Adr == '0));

    assign fsm_state = state;

    // Next read data per port: the array value, then the write bypass,
    // then the forced zero for register 0.
    always_comb begin
        rd_a = mem[R_Adr];
        rd_b = mem[S_Adr];
        if (wr_accept && (W_Adr == R_Adr)) begin
            rd_a = W;
        end
        if (wr_accept && (W_Adr == S_Adr)) begin
            rd_b = W;
        end
        if (zero_r0_en && (R_Adr == '0)) begin
            rd_a = '0;
        end
        if (zero_r0_en && (S_Adr == '0)) begin
            rd_b = '0;
        end
    end

    // Storage array: the sweep has priority, though writes are never
    // accepted while it runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == SWEEP) begin
            mem[ptr] <= '0;
        end else if (wr_store) begin
            mem[W_Adr] <= W;
        end
    end

    // Registered read ports: load on re, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DA <= '0;
            DB <= '0;
        end else if (re) begin
            DA <= rd_a;
            DB <= rd_b;
        end
    end

    // Clear-sweep controller with registered busy and clr_done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    // This edge zeroes the last register, so the sweep ends here.
                    if (ptr == '1) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Refused-write pulse, one cycle after the refused request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && (state == SWEEP);
        end
    end

endmodule
